// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage
//   Instruction-decode stage of the 16-bit fetch/decode/execute pipeline.
//   Decodes a 16-bit instruction word, reads two operands from the internal
//   register file (R0 hard-wired to zero) and presents the decoded bundle to
//   the execute stage through a registered valid/ready output slot. The
//   register-file write port is driven by execute-stage writeback.
//
//   Instruction encoding: [15:12] op, [11:9] rd, [8:6] rs1, [5:3] rs2,
//   [5:0] imm6 (I-type only).
//     op 0-4 : R-type, opcode = op, data2 = R[rs2], writes rd
//     op 5   : ADDI, opcode = ADD, data2 = sext(imm6), writes rd
//     op 6-F : bubble, opcode = F (NOP), data1 = data2 = 0, no write
//
// Parameters
//   DATA_W      operand / register width
//   REG_CNT     number of registers (3-bit addresses, fixed by the encoding)
//   RESET_REGS  1: reset clears the register file, 0: register file not reset
//
// Optional feature
//   ID_WB_BYPASS_EN  when defined, a writeback to rs1/rs2 in the same cycle an
//                    instruction is accepted forwards wb_data into the operand.
//                    When undefined the operand sees the old register value.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   in_valid, in_ready    instruction input handshake
//   instr_in              instruction word
//   out_valid, out_ready  decoded-bundle output handshake
//   opcode                ALU opcode (0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, F NOP)
//   data1, data2          operands
//   rd_out, wen_out       destination register and its write enable
//   wb_en, wb_addr,       register-file writeback port
//   wb_data
// -----------------------------------------------------------------------------
module id_stage #(
  parameter int DATA_W     = 16,
  parameter int REG_CNT    = 8,
  parameter bit RESET_REGS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instr_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        opcode,
  output logic [DATA_W-1:0] data1,
  output logic [DATA_W-1:0] data2,
  output logic [2:0]        rd_out,
  output logic              wen_out,
  input  logic              wb_en,
  input  logic [2:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data
);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_NOP  = 4'hF;

  // R0 has no storage: entry i holds register i+1.
  logic [DATA_W-1:0] regs [REG_CNT-1];

  logic [3:0]        op;
  logic [2:0]        rd;
  logic [2:0]        rs1;
  logic [2:0]        rs2;
  logic [5:0]        imm6;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic [3:0]        dec_opcode;
  logic [DATA_W-1:0] dec_data1;
  logic [DATA_W-1:0] dec_data2;
  logic              dec_wen;
  logic              accept;
  logic              wb_hit;

  assign op      = instr_in[15:12];
  assign rd      = instr_in[11:9];
  assign rs1     = instr_in[8:6];
  assign rs2     = instr_in[5:3];
  assign imm6    = instr_in[5:0];
  assign imm_ext = {{(DATA_W-6){imm6[5]}}, imm6};

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign wb_hit   = wb_en && (wb_addr != 3'd0);

  // Operand read ports; R0 always reads zero.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (rs1 != 3'd0) begin
      rdata1 = regs[rs1 - 3'd1];
`ifdef ID_WB_BYPASS_EN
      if (wb_en && (wb_addr == rs1)) rdata1 = wb_data;
`endif
    end
    if (rs2 != 3'd0) begin
      rdata2 = regs[rs2 - 3'd1];
`ifdef ID_WB_BYPASS_EN
      if (wb_en && (wb_addr == rs2)) rdata2 = wb_data;
`endif
    end
  end

  // Instruction decode into the bundle that is captured on acceptance.
  always_comb begin
    dec_opcode = OP_NOP;
    dec_data1  = '0;
    dec_data2  = '0;
    dec_wen    = 1'b0;
    if (op <= OP_XOR) begin
      dec_opcode = op;
      dec_data1  = rdata1;
      dec_data2  = rdata2;
      dec_wen    = 1'b1;
    end else if (op == OP_ADDI) begin
      dec_opcode = OP_ADD;
      dec_data1  = rdata1;
      dec_data2  = imm_ext;
      dec_wen    = 1'b1;
    end
  end

  // Register file write port; writeback is independent of output stalls.
  generate
    if (RESET_REGS) begin : g_regs_reset
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < REG_CNT - 1; i++) regs[i] <= '0;
        end else if (wb_hit) begin
          regs[wb_addr - 3'd1] <= wb_data;
        end
      end
    end else begin : g_regs_noreset
      always_ff @(posedge clk) begin
        if (wb_hit) regs[wb_addr - 3'd1] <= wb_data;
      end
    end
  endgenerate

  // Output slot: loads on acceptance, empties when consumed with nothing new,
  // and holds everything while the execute stage stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      opcode    <= OP_NOP;
      data1     <= '0;
      data2     <= '0;
      rd_out    <= 3'd0;
      wen_out   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      opcode    <= dec_opcode;
      data1     <= dec_data1;
      data2     <= dec_data2;
      rd_out    <= rd;
      wen_out   <= dec_wen;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
